// File: rtl/replay_unit_if.sv
// Bundle of checkpoint, recovery-command and core-restore signals for replay_unit.
// master = controller/core side, slave = replay_unit.
interface replay_unit_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ckpt_we_i;
  logic [ADDR_WIDTH-1:0] ckpt_addr_i;
  logic [DATA_WIDTH-1:0] ckpt_wdata_i;
  logic                  ckpt_pc_valid_i;
  logic [DATA_WIDTH-1:0] ckpt_pc_i;
  logic                  halt_i;
  logic                  resume_i;
  logic                  we_spc_i;
  logic                  we_sgpr_i;
  logic [ADDR_WIDTH-1:0] replay_addr_i;
  logic                  halted_o;
  logic                  core_halt_o;
  logic                  pc_we_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic                  parity_err_o;

  modport master (
    output ckpt_we_i, ckpt_addr_i, ckpt_wdata_i, ckpt_pc_valid_i, ckpt_pc_i,
           halt_i, resume_i, we_spc_i, we_sgpr_i, replay_addr_i,
    input  halted_o, core_halt_o, pc_we_o, pc_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           parity_err_o
  );

  modport slave (
    input  ckpt_we_i, ckpt_addr_i, ckpt_wdata_i, ckpt_pc_valid_i, ckpt_pc_i,
           halt_i, resume_i, we_spc_i, we_sgpr_i, replay_addr_i,
    output halted_o, core_halt_o, pc_we_o, pc_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           parity_err_o
  );
endinterface

// File: rtl/replay_unit.sv
// Shadows committed GPR/PC writes; on halt drains, then replays shadow state into the core.
// Optional feature macro REPLAY_PARITY_EN: even parity per shadow entry, checked on replay.
module replay_unit #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  replay_unit_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  halted_q, halted_d;
  logic                  core_halt_q, core_halt_d;
  logic                  pc_we_q, pc_we_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  perr_q, perr_d;

  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0] spc_q;
  logic                  capture_en_c;
  logic                  gpr_perr_c;
  logic                  pc_perr_c;

  assign capture_en_c = (state_q != ST_HALTED);

`ifdef REPLAY_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             spar_q;

  assign gpr_perr_c = (^shadow_q[bus.replay_addr_i]) != par_q[bus.replay_addr_i];
  assign pc_perr_c  = (^spc_q) != spar_q;
`else
  assign gpr_perr_c = 1'b0;
  assign pc_perr_c  = 1'b0;
`endif

  // Shadow capture; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
      spc_q <= '0;
`ifdef REPLAY_PARITY_EN
      par_q  <= '0;
      spar_q <= 1'b0;
`endif
    end else if (capture_en_c) begin
      if (bus.ckpt_we_i && (bus.ckpt_addr_i != '0)) begin
        shadow_q[bus.ckpt_addr_i] <= bus.ckpt_wdata_i;
`ifdef REPLAY_PARITY_EN
        par_q[bus.ckpt_addr_i] <= ^bus.ckpt_wdata_i;
`endif
      end
      if (bus.ckpt_pc_valid_i) begin
        spc_q <= bus.ckpt_pc_i;
`ifdef REPLAY_PARITY_EN
        spar_q <= ^bus.ckpt_pc_i;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      core_halt_q <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_q        <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      core_halt_q <= core_halt_d;
      pc_we_q     <= pc_we_d;
      pc_q        <= pc_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      perr_q      <= perr_d;
    end
  end

  // Next state and registered outputs; restore requests are honoured only from HALTED.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halted_d    = halted_q;
    core_halt_d = core_halt_q;
    pc_we_d     = 1'b0;
    pc_d        = pc_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    perr_d      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.halt_i) begin
          state_d     = ST_DRAIN;
          cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
          core_halt_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (bus.resume_i) begin
          state_d     = ST_RUN;
          halted_d    = 1'b0;
          core_halt_d = 1'b0;
        end
        if (bus.we_spc_i) begin
          pc_we_d = 1'b1;
          pc_d    = spc_q;
        end
        if (bus.we_sgpr_i) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.replay_addr_i;
          rf_wdata_d = shadow_q[bus.replay_addr_i];
        end
        perr_d = (bus.we_spc_i && pc_perr_c) || (bus.we_sgpr_i && gpr_perr_c);
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.halted_o     = halted_q;
  assign bus.core_halt_o  = core_halt_q;
  assign bus.pc_we_o      = pc_we_q;
  assign bus.pc_o         = pc_q;
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_waddr_o   = rf_waddr_q;
  assign bus.rf_wdata_o   = rf_wdata_q;
  assign bus.parity_err_o = perr_q;

endmodule

// File: tb/tb_replay_unit.sv
// Scoreboard bench for replay_unit: a bench-side shadow model predicts every replayed value.
module tb_replay_unit;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DRAIN = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  logic clk;
  logic rst_n;

  replay_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  replay_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [2**AW];
  logic [DW-1:0] mdl_pc;
  logic          mdl_capture;
  exp_t          rf_exp [$];
  logic [DW-1:0] pc_exp [$];
  exp_t          e;
  logic [DW-1:0] pe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ckpt_we_i       = 1'b0;
    bus.ckpt_addr_i     = '0;
    bus.ckpt_wdata_i    = '0;
    bus.ckpt_pc_valid_i = 1'b0;
    bus.ckpt_pc_i       = '0;
    bus.halt_i          = 1'b0;
    bus.resume_i        = 1'b0;
    bus.we_spc_i        = 1'b0;
    bus.we_sgpr_i       = 1'b0;
    bus.replay_addr_i   = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
    mdl_pc      = '0;
    mdl_capture = 1'b1;
    rf_exp.delete();
    pc_exp.delete();
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic pcv, input logic [DW-1:0] pc);
    bus.ckpt_we_i       = 1'b1;
    bus.ckpt_addr_i     = a;
    bus.ckpt_wdata_i    = d;
    bus.ckpt_pc_valid_i = pcv;
    bus.ckpt_pc_i       = pc;
    if (mdl_capture) begin
      if (a != '0) mdl[a] = d;
      if (pcv) mdl_pc = pc;
    end
  endtask

  task automatic req_gpr(input logic [AW-1:0] a);
    bus.we_sgpr_i     = 1'b1;
    bus.replay_addr_i = a;
    rf_exp.push_back('{addr: a, data: mdl[a], perr: 1'b0});
  endtask

  task automatic req_pc();
    bus.we_spc_i = 1'b1;
    pc_exp.push_back(mdl_pc);
  endtask

  task automatic go_halted();
    bus.halt_i = 1'b1;
    step();
    bus.halt_i = 1'b0;
    repeat (DRAIN) step();
    mdl_capture = 1'b0;
  endtask

  task automatic go_run();
    bus.resume_i = 1'b1;
    step();
    bus.resume_i = 1'b0;
    mdl_capture  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_clear();
    repeat (3) step();
    checks++;
    if ({bus.halted_o, bus.core_halt_o, bus.pc_we_o, bus.rf_we_o, bus.parity_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.halted_o, bus.core_halt_o, bus.pc_we_o, bus.rf_we_o, bus.parity_err_o});
    end
    checks++;
    if ({bus.pc_o, bus.rf_waddr_o, bus.rf_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got pc=%h addr=%0d data=%h required all 0",
               bus.pc_o, bus.rf_waddr_o, bus.rf_wdata_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_restore();
    commit(5'd5, 32'hDEADBEEF, 1'b1, 32'h100);
    step();
    idle();
    go_halted();
    checks++;
    if (bus.halted_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_halted: got %b required 1", bus.halted_o);
    end
    req_pc();
    step();
    idle();
    pe = pc_exp.pop_front();
    checks++;
    if ({bus.pc_we_o, bus.pc_o, bus.parity_err_o} !== {1'b1, pe, 1'b0}) begin
      errors++;
      $display("FAIL basic_pc: got we=%b pc=%h perr=%b required we=1 pc=%h perr=0",
               bus.pc_we_o, bus.pc_o, bus.parity_err_o, pe);
    end
    req_gpr(5'd5);
    step();
    idle();
    checks++;
    if ({bus.pc_we_o, bus.pc_o} !== {1'b0, 32'h100}) begin
      errors++;
      $display("FAIL pc_pulse_hold: got we=%b pc=%h required we=0 pc=00000100",
               bus.pc_we_o, bus.pc_o);
    end
    e = rf_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o} !== {1'b1, e.addr, e.data, e.perr}) begin
      errors++;
      $display("FAIL basic_gpr: got we=%b addr=%0d data=%h perr=%b required we=1 addr=%0d data=%h perr=%b",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o, e.addr, e.data, e.perr);
    end
    step();
    checks++;
    if ({bus.rf_we_o, bus.rf_wdata_o} !== {1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL gpr_pulse_hold: got we=%b data=%h required we=0 data=deadbeef",
               bus.rf_we_o, bus.rf_wdata_o);
    end
    req_pc();
    req_gpr(5'd5);
    step();
    idle();
    pe = pc_exp.pop_front();
    e  = rf_exp.pop_front();
    checks++;
    if ({bus.pc_we_o, bus.pc_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !==
        {1'b1, pe, 1'b1, e.addr, e.data}) begin
      errors++;
      $display("FAIL simultaneous: got pcwe=%b pc=%h rfwe=%b addr=%0d data=%h required 1 %h 1 %0d %h",
               bus.pc_we_o, bus.pc_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, pe, e.addr, e.data);
    end
  endtask

  task automatic test_drain_timing();
    go_run();
    checks++;
    if ({bus.halted_o, bus.core_halt_o} !== 2'b00) begin
      errors++;
      $display("FAIL resume_clear: got halted=%b core_halt=%b required 0 0", bus.halted_o, bus.core_halt_o);
    end
    commit(5'd8, 32'hA5A5_0008, 1'b0, '0);
    bus.halt_i = 1'b1;
    step();
    idle();
    checks++;
    if ({bus.core_halt_o, bus.halted_o} !== 2'b10) begin
      errors++;
      $display("FAIL drain_edge_n: got core_halt=%b halted=%b required 1 0", bus.core_halt_o, bus.halted_o);
    end
    step();
    checks++;
    if (bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_edge_n1: got halted=%b required 0", bus.halted_o);
    end
    commit(5'd7, 32'h55, 1'b0, '0);
    step();
    idle();
    checks++;
    if (bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_edge_n2: got halted=%b required 0", bus.halted_o);
    end
    step();
    mdl_capture = 1'b0;
    checks++;
    if ({bus.halted_o, bus.core_halt_o} !== 2'b11) begin
      errors++;
      $display("FAIL drain_edge_n3: got halted=%b core_halt=%b required 1 1", bus.halted_o, bus.core_halt_o);
    end
    commit(5'd7, 32'h77, 1'b1, 32'h999);
    step();
    idle();
    req_gpr(5'd7);
    step();
    e = rf_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, e.addr, e.data}) begin
      errors++;
      $display("FAIL drain_capture_x7: got we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, e.addr, e.data);
    end
    req_gpr(5'd8);
    req_pc();
    step();
    idle();
    e  = rf_exp.pop_front();
    pe = pc_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.pc_we_o, bus.pc_o} !==
        {1'b1, e.addr, e.data, 1'b1, pe}) begin
      errors++;
      $display("FAIL halt_cycle_capture: got rfwe=%b addr=%0d data=%h pcwe=%b pc=%h required 1 %0d %h 1 %h",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.pc_we_o, bus.pc_o, e.addr, e.data, pe);
    end
  endtask

  task automatic test_ignored_requests();
    bus.halt_i = 1'b1;
    step();
    idle();
    step();
    checks++;
    if ({bus.halted_o, bus.core_halt_o} !== 2'b11) begin
      errors++;
      $display("FAIL halt_in_halted: got halted=%b core_halt=%b required 1 1", bus.halted_o, bus.core_halt_o);
    end
    go_run();
    bus.resume_i      = 1'b1;
    bus.we_sgpr_i     = 1'b1;
    bus.replay_addr_i = 5'd3;
    bus.we_spc_i      = 1'b1;
    step();
    idle();
    checks++;
    if ({bus.halted_o, bus.core_halt_o, bus.rf_we_o, bus.pc_we_o} !== 4'b0000) begin
      errors++;
      $display("FAIL requests_in_run: got %b required 0000",
               {bus.halted_o, bus.core_halt_o, bus.rf_we_o, bus.pc_we_o});
    end
    commit(5'd3, 32'h3333_0003, 1'b0, '0);
    step();
    idle();
    go_halted();
    bus.resume_i = 1'b1;
    req_gpr(5'd3);
    step();
    idle();
    mdl_capture = 1'b1;
    e = rf_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.halted_o, bus.core_halt_o} !==
        {1'b1, e.addr, e.data, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL resume_with_gpr: got we=%b addr=%0d data=%h halted=%b core_halt=%b required 1 %0d %h 0 0",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.halted_o, bus.core_halt_o, e.addr, e.data);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 2**AW; a++) begin
      commit(AW'(a), $urandom, 1'b0, '0);
      step();
    end
    idle();
    go_halted();
    for (int a = 0; a < 2**AW; a++) begin
      req_gpr(AW'(a));
      step();
      e = rf_exp.pop_front();
      checks++;
      if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o} !== {1'b1, e.addr, e.data, e.perr}) begin
        errors++;
        $display("FAIL sweep a=%0d: got we=%b addr=%0d data=%h perr=%b required we=1 addr=%0d data=%h perr=%b",
                 a, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o, e.addr, e.data, e.perr);
      end
    end
    idle();
    step();
    checks++;
    if (bus.rf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: got we=%b required 0", bus.rf_we_o);
    end
  endtask

  task automatic test_reset_mid_restore();
    for (int a = 0; a <= 12; a++) begin
      req_gpr(AW'(a));
      if (a == 12) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rf_we_o, bus.pc_we_o, bus.halted_o, bus.core_halt_o, bus.rf_wdata_o} !== '0) begin
          errors++;
          $display("FAIL reset_mid: got rfwe=%b pcwe=%b halted=%b core_halt=%b data=%h required all 0",
                   bus.rf_we_o, bus.pc_we_o, bus.halted_o, bus.core_halt_o, bus.rf_wdata_o);
        end
      end else begin
        step();
        e = rf_exp.pop_front();
        checks++;
        if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, e.addr, e.data}) begin
          errors++;
          $display("FAIL pre_reset a=%0d: got we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                   a, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, e.addr, e.data);
        end
      end
    end
    idle();
    model_clear();
    step();
    step();
    rst_n = 1'b1;
    step();
    go_halted();
    req_gpr(5'd12);
    step();
    idle();
    e = rf_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, e.addr, e.data}) begin
      errors++;
      $display("FAIL post_reset_x12: got we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, e.addr, e.data);
    end
  endtask

  task automatic test_parity();
`ifdef REPLAY_PARITY_EN
    dut.shadow_q[9][0] = ~dut.shadow_q[9][0];
    bus.we_sgpr_i     = 1'b1;
    bus.replay_addr_i = 5'd9;
    rf_exp.push_back('{addr: 5'd9, data: mdl[9] ^ 32'h1, perr: 1'b1});
`else
    req_gpr(5'd9);
`endif
    step();
    idle();
    e = rf_exp.pop_front();
    checks++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o} !== {1'b1, e.addr, e.data, e.perr}) begin
      errors++;
      $display("FAIL parity_x9: got we=%b addr=%0d data=%h perr=%b required we=1 addr=%0d data=%h perr=%b",
               bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.parity_err_o, e.addr, e.data, e.perr);
    end
    step();
    checks++;
    if ({bus.rf_we_o, bus.parity_err_o} !== 2'b00) begin
      errors++;
      $display("FAIL parity_pulse: got we=%b perr=%b required 0 0", bus.rf_we_o, bus.parity_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_restore();
    test_drain_timing();
    test_ignored_requests();
    test_back_to_back();
    test_reset_mid_restore();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/replay_unit.md
# replay_unit

Checkpoint-and-restore responder for the fault-tolerant core pair. Mirrors every committed register-file write and committed PC into a shadow store during normal execution. On command from the recovery controller it halts the core, reports halted, and replays the shadow PC and GPRs into the core through its write ports. It is the target end of the controller's halt/halted, we_spc, we_sgpr and replay_addr signals.

## Interface
- ADDR_WIDTH, 5, GPR address width; shadow depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, GPR and PC width
- DRAIN_CYCLES, 3, cycles from halt request to halted (pipeline drain), minimum 1
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset; system reset only, never the controller's core reset
- ckpt_we_i  in  1  core committed a GPR write this cycle
- ckpt_addr_i  in  ADDR_WIDTH  committed GPR address
- ckpt_wdata_i  in  DATA_WIDTH  committed GPR data
- ckpt_pc_valid_i  in  1  core committed an instruction this cycle
- ckpt_pc_i  in  DATA_WIDTH  committed PC
- halt_i  in  1  single-cycle halt request from controller
- resume_i  in  1  resume request from controller
- we_spc_i  in  1  restore PC request
- we_sgpr_i  in  1  restore one GPR request
- replay_addr_i  in  ADDR_WIDTH  GPR to restore
- halted_o  out  1  level, high while in HALTED
- core_halt_o  out  1  halt drive to core
- pc_we_o  out  1  PC write strobe to core
- pc_o  out  DATA_WIDTH  restored PC
- rf_we_o  out  1  GPR write strobe to core
- rf_waddr_o  out  ADDR_WIDTH  restored GPR address
- rf_wdata_o  out  DATA_WIDTH  restored GPR data
- parity_err_o  out  1  shadow parity mismatch on a replayed entry

## Operation
- Reset: state RUN, all outputs 0, all shadow entries and shadow PC 0.
- Shadow store: 2**ADDR_WIDTH x DATA_WIDTH registers plus one PC register. Entry 0 is never written and always reads 0.
- Capture: enabled in RUN and DRAIN, frozen in HALTED. ckpt_we_i with ckpt_addr_i != 0 writes the entry on that clock edge. ckpt_pc_valid_i writes the shadow PC.
- FSM:
  - RUN: halt_i goes to DRAIN and loads the counter with DRAIN_CYCLES-1. core_halt_o rises on the same edge.
  - DRAIN: counter decrements each cycle. At counter==0 the FSM goes to HALTED. In-flight commits are still captured.
  - HALTED: halted_o=1, core_halt_o=1. resume_i goes to RUN; halted_o and core_halt_o clear on that edge.
- Ignored requests: halt_i outside RUN, resume_i outside HALTED, we_spc_i/we_sgpr_i outside HALTED.
- Restore, valid in HALTED only:
  - we_spc_i gives pc_we_o=1 and pc_o=shadow PC on the next cycle.
  - we_sgpr_i gives rf_we_o=1, rf_waddr_o=replay_addr_i, rf_wdata_o=shadow[replay_addr_i] on the next cycle.
  - Strobes last exactly one cycle. The data outputs hold their last value otherwise.
- Simultaneous events:
  - we_spc_i and we_sgpr_i in the same cycle: both are issued next cycle.
  - resume_i together with we_sgpr_i: the write is still issued next cycle, with the FSM already in RUN.
  - ckpt_we_i together with halt_i: the write is captured.
- Back-to-back we_sgpr_i every cycle sustains one GPR write per cycle; no stalls.
- rst_ni asserted mid-restore: immediate return to reset state, shadow cleared, strobes dropped.

## Timing
- halt_i at edge N: core_halt_o=1 after N; halted_o=1 after edge N+DRAIN_CYCLES.
- Restore latency: 1 cycle, request to strobe.
- resume_i at edge M: halted_o=0 and core_halt_o=0 after M.
- Capture is visible to a replay read on the cycle after the commit.

## Configuration
- REPLAY_PARITY_EN defined:
  - Each shadow entry and the shadow PC store an even-parity bit computed at capture.
  - On each restore the parity is recomputed. A mismatch pulses parity_err_o for one cycle, aligned with the corresponding strobe.
  - The strobe is still issued.
- REPLAY_PARITY_EN undefined: no parity storage; parity_err_o tied 0.

## Test plan
- Capture x5=0xDEADBEEF and PC=0x100, halt, wait halted_o, we_spc_i then we_sgpr_i addr 5 -> pc_we_o with pc_o=0x100, then rf_we_o with addr 5 and data 0xDEADBEEF, each 1 cycle after its request.
- DRAIN_CYCLES=3, halt_i at cycle 10 -> core_halt_o high after edge 10, halted_o high after edge 13. A ckpt write to x7=0x55 at cycle 12 is captured; one at cycle 14 is not.
- Full sweep: we_sgpr_i addr 0..31 on consecutive cycles -> 32 consecutive rf_we_o pulses, x0 data 0, others equal to captured values.
- halt_i in HALTED and resume_i in RUN -> no state change. resume_i with we_sgpr_i addr 3 -> write issued next cycle, halted_o low.
- rst_ni low mid-sweep at addr 12 -> all strobes 0 immediately; after release, replaying addr 12 gives data 0.
- REPLAY_PARITY_EN: force-flip bit 0 of shadow x9, replay addr 9 -> parity_err_o pulses with rf_we_o. Without the macro -> parity_err_o stays 0.
